// File: rtl/winograd_input_transform_if.sv
// Tile-bundle input and transformed-tile output handshakes of the Winograd input transform.
interface winograd_input_transform_if #(
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int PIX_W = 8,
  parameter int OUT_W = 11
);
  localparam int CH_W = (M > 1) ? $clog2(M) : 1;

  logic [M*N*N*PIX_W-1:0] tile;
  logic                   tile_valid;
  logic                   tile_ready;
  logic [N*N*OUT_W-1:0]   v_tile;
  logic                   v_valid;
  logic                   v_ready;
  logic [CH_W-1:0]        v_channel;
  logic                   v_last;
  logic                   proc_finish;

  modport master (
    output tile, tile_valid, v_ready,
    input  tile_ready, v_tile, v_valid, v_channel, v_last, proc_finish
  );

  modport slave (
    input  tile, tile_valid, v_ready,
    output tile_ready, v_tile, v_valid, v_channel, v_last, proc_finish
  );
endinterface

// File: rtl/winograd_input_transform.sv
// Winograd F(2x2,3x3) input transform: V = B^T * d * B, one channel of a captured bundle at a time.
// state | meaning
// IDLE  | ready for a bundle
// ROW   | T = B^T * d for current channel
// COL   | V = T * B into output register
// OUT   | V presented, waiting for consumer
// DONE  | bundle finished, proc_finish high
module winograd_input_transform #(
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int PIX_W = 8,
  parameter int OUT_W = 11
) (
  input logic                       clk,
  input logic                       rst,
  winograd_input_transform_if.slave bus
);
  localparam int CH_W   = (M > 1) ? $clog2(M) : 1;
  localparam int TILE_W = M*N*N*PIX_W;

  typedef enum logic [2:0] {IDLE, ROW, COL, OUT, DONE} state_t;

  state_t                   state;
  logic [TILE_W-1:0]        d_reg;
  logic [CH_W-1:0]          ch;
  logic signed [OUT_W-1:0]  t_reg  [N][N];
  logic signed [OUT_W-1:0]  d_sel  [N][N];
  logic signed [OUT_W-1:0]  t_next [N][N];
  logic signed [OUT_W-1:0]  v_next [N][N];

  // Pixels are unsigned, so zero-extend before any subtraction.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        d_sel[j][k] = $signed({{(OUT_W-PIX_W){1'b0}},
                               d_reg[int'(ch)*N*N*PIX_W + j*N*PIX_W + k*PIX_W +: PIX_W]});
      end
    end
    for (int k = 0; k < N; k++) begin
      t_next[0][k] = d_sel[0][k] - d_sel[2][k];
      t_next[1][k] = d_sel[1][k] + d_sel[2][k];
      t_next[2][k] = d_sel[2][k] - d_sel[1][k];
      t_next[3][k] = d_sel[1][k] - d_sel[3][k];
    end
    for (int j = 0; j < N; j++) begin
      v_next[j][0] = t_reg[j][0] - t_reg[j][2];
      v_next[j][1] = t_reg[j][1] + t_reg[j][2];
      v_next[j][2] = t_reg[j][2] - t_reg[j][1];
      v_next[j][3] = t_reg[j][1] - t_reg[j][3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      d_reg           <= '0;
      ch              <= '0;
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          t_reg[j][k] <= '0;
        end
      end
      bus.tile_ready  <= 1'b1;
      bus.v_tile      <= '0;
      bus.v_valid     <= 1'b0;
      bus.v_channel   <= '0;
      bus.v_last      <= 1'b0;
      bus.proc_finish <= 1'b0;
    end else begin
      bus.proc_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tile_valid) begin
            d_reg          <= bus.tile;
            ch             <= '0;
            bus.tile_ready <= 1'b0;
            state          <= ROW;
          end
        end
        ROW: begin
          t_reg <= t_next;
          state <= COL;
        end
        COL: begin
          for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
              bus.v_tile[(j*N+k)*OUT_W +: OUT_W] <= v_next[j][k];
            end
          end
          bus.v_valid   <= 1'b1;
          bus.v_channel <= ch;
          bus.v_last    <= (ch == CH_W'(M-1));
          state         <= OUT;
        end
        OUT: begin
          if (bus.v_ready) begin
            bus.v_valid <= 1'b0;
            bus.v_last  <= 1'b0;
            if (ch == CH_W'(M-1)) begin
              bus.proc_finish <= 1'b1;
              state           <= DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= ROW;
            end
          end
        end
        DONE: begin
          bus.tile_ready <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_winograd_input_transform.sv
// Self-checking bench: matrix-product model of B^T d B with a per-cycle output monitor.
module tb_winograd_input_transform;
  localparam int M      = 3;
  localparam int N      = 4;
  localparam int PIX_W  = 8;
  localparam int OUT_W  = 11;
  localparam int TILE_W = M*N*N*PIX_W;
  localparam int VT_W   = N*N*OUT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  winograd_input_transform_if #(.M(M), .N(N), .PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

  winograd_input_transform #(.M(M), .N(N), .PIX_W(PIX_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [VT_W-1:0] exp_v[$];
  int              exp_ch[$];
  int              fin_cnt    = 0;
  int              accept_cnt = 0;
  bit              busy       = 0;
  bit              prev_fin   = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [VT_W-1:0] act, input logic [VT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // V = B^T d B computed as two plain matrix products.
  function automatic logic [VT_W-1:0] model_v(input logic [TILE_W-1:0] t, input int c);
    int bt[4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
    int d[4][4];
    int tmp[4][4];
    int acc;
    logic [VT_W-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        d[j][k] = int'(t[c*N*N*PIX_W + j*N*PIX_W + k*PIX_W +: PIX_W]);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc += bt[i][j] * d[j][k];
        tmp[i][k] = acc;
      end
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < 4; l++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += tmp[i][k] * bt[l][k];
        r[(i*N+l)*OUT_W +: OUT_W] = OUT_W'(acc);
      end
    return r;
  endfunction

  function automatic int get_el(input logic [VT_W-1:0] vt, input int j, input int k);
    logic signed [OUT_W-1:0] e;
    e = vt[(j*N+k)*OUT_W +: OUT_W];
    return int'(e);
  endfunction

  function automatic logic [TILE_W-1:0] fill_rows(input logic [7:0] r0, input logic [7:0] r1,
                                                  input logic [7:0] r2, input logic [7:0] r3);
    logic [TILE_W-1:0] t;
    logic [7:0] rv[4];
    rv = '{r0, r1, r2, r3};
    for (int c = 0; c < M; c++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          t[c*N*N*PIX_W + j*N*PIX_W + k*PIX_W +: PIX_W] = rv[j];
    return t;
  endfunction

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] t;
    for (int i = 0; i < TILE_W/32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Output monitor: checks every cycle against the expected-V queue and the busy rule.
  always @(negedge clk) begin
    if (rst) begin
      exp_v.delete();
      exp_ch.delete();
      busy     = 0;
      prev_fin = 0;
    end else begin
      check("tile_ready", bus.tile_ready, !busy);
      if (bus.v_valid) begin
        if (exp_v.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL v_valid_unexpected actual=1 required=0 at %0t", $time);
        end else begin
          check_vec("v_tile", bus.v_tile, exp_v[0]);
          check("v_channel", bus.v_channel, exp_ch[0]);
          check("v_last", bus.v_last, exp_ch[0] == M-1);
          if (bus.v_ready) begin
            void'(exp_v.pop_front());
            void'(exp_ch.pop_front());
          end
        end
      end else begin
        check("v_last_idle", bus.v_last, 0);
      end
      if (bus.proc_finish) begin
        check("finish_queue_empty", exp_v.size(), 0);
        check("finish_pulse_width", prev_fin, 0);
        fin_cnt++;
        busy = 0;
      end
      prev_fin = bus.proc_finish;
      if (bus.tile_valid && bus.tile_ready) begin
        for (int c = 0; c < M; c++) begin
          exp_v.push_back(model_v(bus.tile, c));
          exp_ch.push_back(c);
        end
        busy = 1;
        accept_cnt++;
      end
    end
  end

  task automatic start_bundle(input logic [TILE_W-1:0] t);
    @(posedge clk); #1;
    bus.tile       = t;
    bus.tile_valid = 1'b1;
    @(posedge clk); #1;
    bus.tile_valid = 1'b0;
  endtask

  task automatic drain(input int max_stall);
    int target;
    int stall;
    target = fin_cnt + 1;
    stall  = 0;
    for (int i = 0; i < 400 && fin_cnt < target; i++) begin
      @(posedge clk); #1;
      if (stall > 0) begin
        bus.v_ready = 1'b0;
        stall--;
      end else begin
        bus.v_ready = 1'b1;
        stall = (max_stall == 0) ? 0 : int'($urandom_range(0, max_stall));
      end
    end
    check("drain_finished", fin_cnt >= target, 1);
    bus.v_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tile_ready"}, bus.tile_ready, 1);
    check({tag, "_v_valid"}, bus.v_valid, 0);
    check({tag, "_v_last"}, bus.v_last, 0);
    check({tag, "_proc_finish"}, bus.proc_finish, 0);
    check({tag, "_v_channel"}, bus.v_channel, 0);
    check_vec({tag, "_v_tile"}, bus.v_tile, '0);
  endtask

  initial begin
    logic [TILE_W-1:0] t;
    logic [VT_W-1:0]   mv;
    int                acc0;
    int                target;

    rst            = 1'b1;
    bus.tile       = '0;
    bus.tile_valid = 1'b0;
    bus.v_ready    = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed pins of the model itself.
    mv = model_v(fill_rows(8'd17, 8'd17, 8'd17, 8'd17), 0);
    check("model_17_v11", get_el(mv, 1, 1), 68);
    check("model_17_v00", get_el(mv, 0, 0), 0);
    mv = model_v(fill_rows(8'd255, 8'd255, 8'd255, 8'd255), 2);
    check("model_255_v11", get_el(mv, 1, 1), 1020);
    check("model_255_v33", get_el(mv, 3, 3), 0);
    mv = model_v(fill_rows(8'd0, 8'd0, 8'd255, 8'd0), 1);
    check("model_row2_v01", get_el(mv, 0, 1), -510);
    check("model_row2_v11", get_el(mv, 1, 1), 510);
    check("model_row2_v21", get_el(mv, 2, 1), 510);
    check("model_row2_v02", get_el(mv, 0, 2), 0);

    // Test 1: constant 17, ready high, latency and finish timing.
    bus.v_ready = 1'b1;
    start_bundle(fill_rows(8'd17, 8'd17, 8'd17, 8'd17));
    @(negedge clk); check("lat_row_v_valid", bus.v_valid, 0);
    @(negedge clk); check("lat_col_v_valid", bus.v_valid, 0);
    @(negedge clk); check("lat_out_v_valid", bus.v_valid, 1);
    check("t1_dut_v11", get_el(bus.v_tile, 1, 1), 68);
    check("t1_dut_v12", get_el(bus.v_tile, 1, 2), 0);
    repeat (6) @(negedge clk);
    check("t1_finish_early", bus.proc_finish, 0);
    @(negedge clk);
    check("t1_finish_at_9", bus.proc_finish, 1);
    @(negedge clk);
    check("t1_idle_at_10", bus.tile_ready, 1);
    check("t1_finish_count", fin_cnt, 1);

    // Test 2: max positive.
    start_bundle(fill_rows(8'd255, 8'd255, 8'd255, 8'd255));
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("t2_dut_v11", get_el(bus.v_tile, 1, 1), 1020);
    drain(0);

    // Test 3: single hot row, with short stalls.
    start_bundle(fill_rows(8'd0, 8'd0, 8'd255, 8'd0));
    drain(2);

    // Test 4: random tiles, random stalls 0..5.
    for (int b = 0; b < 4; b++) begin
      start_bundle(rand_tile());
      drain(5);
    end

    // Test 5: tile_valid held high; tile changed mid-bundle must not be captured early.
    acc0   = accept_cnt;
    target = fin_cnt + 2;
    @(posedge clk); #1;
    bus.v_ready    = 1'b1;
    bus.tile       = rand_tile();
    bus.tile_valid = 1'b1;
    for (int i = 0; i < 100 && fin_cnt < target; i++) begin
      @(posedge clk); #1;
      if (i == 4) bus.tile = rand_tile();
    end
    bus.tile_valid = 1'b0;
    check("t5_finished", fin_cnt >= target, 1);
    check("t5_accept_count", accept_cnt - acc0, 2);

    // Test 6: reset during OUT of channel 1.
    bus.v_ready = 1'b0;
    start_bundle(rand_tile());
    for (int i = 0; i < 20 && !bus.v_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.v_ready = 1'b1;
    @(posedge clk); #1;
    bus.v_ready = 1'b0;
    for (int i = 0; i < 20 && !(bus.v_valid && bus.v_channel == 1); i++) @(negedge clk);
    check("t6_reached_ch1", bus.v_valid && bus.v_channel == 1, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.v_ready = 1'b1;
    start_bundle(rand_tile());
    drain(1);

    repeat (3) @(negedge clk);
    check("end_queue_empty", exp_v.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
